// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared state encoding, constants and helpers for the iterative divider
package riscv_div_pkg;
    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_t;
    localparam int DIV_MAX_WIDTH = 64;
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_BY_ZERO_Q = '1;
    // Magnitude of a w-bit value held zero-extended; callers keep the low w bits
    function automatic logic [DIV_MAX_WIDTH-1:0] abs_mag(input logic [DIV_MAX_WIDTH-1:0] val, input int w, input logic signed_op);
        return (signed_op && val[w-1]) ? -val : val;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] shifted, trial;
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dmag};
    assign rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_n   = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module iterative_divider import riscv_div_pkg::*; #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    div_state_t state, state_n;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] rem, quo, dmag, rem_n, quo_n, dvd_abs, dvs_abs, q_fix, r_fix;
    logic neg_q, neg_r, accept, div_zero, overflow;
    assign accept   = start && (state == DIV_IDLE || state == DIV_DONE);
    assign div_zero = divisor == '0;
    assign overflow = is_signed && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
    assign dvd_abs  = WIDTH'(abs_mag(DIV_MAX_WIDTH'(dividend), WIDTH, is_signed));
    assign dvs_abs  = WIDTH'(abs_mag(DIV_MAX_WIDTH'(divisor), WIDTH, is_signed));
    assign q_fix    = neg_q ? -quo : quo;
    assign r_fix    = neg_r ? -rem : rem;
    div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .quo(quo), .dmag(dmag), .rem_n(rem_n), .quo_n(quo_n));
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_n;
    end
    // Next state and handshake outputs; DONE accepts a new request like IDLE
    always_comb begin
        state_n = state;
        busy    = state == DIV_CALC || state == DIV_FIX;
        done    = state == DIV_DONE;
        state_n = accept ? ((div_zero || overflow) ? DIV_DONE : DIV_CALC) :
                  state == DIV_CALC ? (count == '0 ? DIV_FIX : DIV_CALC) :
                  state == DIV_FIX ? DIV_DONE : DIV_IDLE;
    end
    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dmag      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            count <= CW'(WIDTH - 1);
            rem   <= '0;
            quo   <= dvd_abs;
            dmag  <= dvs_abs;
            neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed && dividend[WIDTH-1];
            if (div_zero) begin
                quotient  <= WIDTH'(DIV_BY_ZERO_Q);
                remainder <= dividend;
            end else if (overflow) begin
                quotient  <= dividend;
                remainder <= '0;
            end
        end else if (state == DIV_CALC) begin
            rem   <= rem_n;
            quo   <= quo_n;
            count <= count - 1'b1;
        end else if (state == DIV_FIX) begin
            quotient  <= q_fix;
            remainder <= r_fix;
        end
    end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed table-driven checks of the iterative divider
module tb_iterative_divider;
    logic clk, rst, start, is_signed, busy, done;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic [31:0] prev_q, prev_r;
    int tests, fails;
    typedef struct {
        logic sgn;
        logic [31:0] a, b, q, r;
        int lat, bsy;
    } vec_t;
    vec_t vt[14];
    vec_t vx;

    iterative_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is observed
    task automatic run(input string name, input vec_t v, input int poke);
        int lat, bcnt;
        logic got, unstable;
        start = 1'b1; is_signed = v.sgn; dividend = v.a; divisor = v.b;
        @(posedge clk);
        lat = 0; bcnt = 0; got = 1'b0; unstable = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (start) begin dividend = 32'd1000; divisor = 32'd3; end
            if (busy) bcnt++;
            if (done) got = 1'b1;
            else if (quotient !== prev_q || remainder !== prev_r) unstable = 1'b1;
        end
        start = 1'b0;
        check({name, " latency"}, lat, v.lat);
        check({name, " busy cycles"}, bcnt, v.bsy);
        check({name, " quotient"}, quotient, v.q);
        check({name, " remainder"}, remainder, v.r);
        check({name, " outputs held"}, {31'd0, unstable}, 32'd0);
        prev_q = v.q; prev_r = v.r;
    endtask

    initial begin
        logic stray;
        tests = 0; fails = 0;
        clk = 0; rst = 0; start = 0; is_signed = 0; dividend = 0; divisor = 0;
        prev_q = 0; prev_r = 0;
        vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34, 33};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   34, 33};
        vt[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34, 33};
        vt[3]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1,  0};
        vt[4]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1,  0};
        vt[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1,  0};
        vt[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   34, 33};
        vt[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   34, 33};
        vt[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          34, 33};
        vt[9]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          34, 33};
        vt[10] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          34, 33};
        vt[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          34, 33};
        vt[12] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          34, 33};
        vt[13] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   34, 33};
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        rst = 1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            run($sformatf("vec%0d", i), vt[i], 0);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
        end
        run("ignored start", vt[0], 5);
        @(negedge clk);
        check("ignored start no extra done", {31'd0, done}, 32'd0);
        @(negedge clk);
        run("b2b first", vt[1], 0);
        run("b2b second", vt[9], 0);
        run("b2b div0", vt[3], 0);
        run("b2b after div0", vt[13], 0);
        @(negedge clk);
        start = 1; is_signed = 0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 0;
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset quotient", quotient, 32'd0);
        check("mid reset remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1;
        prev_q = 0; prev_r = 0;
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) stray = 1'b1;
        end
        check("no stray done after reset", {31'd0, stray}, 32'd0);
        vx = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 34, 33};
        run("after reset", vx, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
